// File: rtl/array_9_port_ctrl.sv
// Request/response front end for the 8-entry masked single-port SRAM macro.
// Turns a valid/ready request stream into RW0 cycles and buffers read data in a small response FIFO.
module array_9_port_ctrl #(
    parameter int ADDR_W        = 3,
    parameter int DEPTH         = 8,
    parameter int DATA_W        = 1176,
    parameter int MASK_W        = 4,
    parameter int RESP_DEPTH    = 3,
    parameter int INIT_ON_RESET = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [MASK_W-1:0] req_mask,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              init_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en,
    output logic              mem_wmode,
    output logic [MASK_W-1:0] mem_wmask,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CW = $clog2(RESP_DEPTH + 1);
    localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam logic [CW:0]       RESP_LIM  = (CW + 1)'(RESP_DEPTH);
    localparam logic [PW-1:0]     PTR_LAST  = PW'(RESP_DEPTH - 1);
    localparam logic [ADDR_W-1:0] SWEEP_END = ADDR_W'(DEPTH - 1);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] sweep_addr;
    logic              rd_pend_p1;
    logic [DATA_W-1:0] fifo_mem [RESP_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     fifo_cnt;

    logic              in_init;
    logic              issue;
    logic              push;
    logic              pop;
    logic [CW:0]       occupancy;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign in_init = (state == ST_INIT);

    // Credits cover buffered responses plus the read whose data lands this cycle.
    assign occupancy  = {1'b0, fifo_cnt} + {{CW{1'b0}}, rd_pend_p1};
    assign req_ready  = !reset && !in_init && (occupancy < RESP_LIM);
    assign issue      = req_valid && req_ready;
    assign init_done  = !reset && !in_init;
    assign resp_valid = !reset && (fifo_cnt != '0);
    assign resp_rdata = fifo_mem[rd_ptr];
    assign push       = rd_pend_p1;
    assign pop        = resp_valid && resp_ready;
    assign mem_en     = !reset && (in_init || issue);

    always_comb begin
        mem_addr  = req_addr;
        mem_wmode = req_write;
        mem_wmask = req_write ? req_mask : '0;
        mem_wdata = req_wdata;
        if (in_init) begin
            mem_addr  = sweep_addr;
            mem_wmode = 1'b1;
            mem_wmask = '1;
            mem_wdata = '0;
        end
    end

    // p0 -> p1: issued read becomes pending; control state and FIFO bookkeeping
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;
            sweep_addr <= '0;
            rd_pend_p1 <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
        end else begin
            if (in_init) begin
                sweep_addr <= sweep_addr + 1'b1;
                if (sweep_addr == SWEEP_END) begin
                    state <= ST_RUN;
                end
            end
            rd_pend_p1 <= issue && !req_write;
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // p1 -> FIFO: macro read data is captured the cycle after issue
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_array_9_port_ctrl.sv
// Bench for array_9_port_ctrl: macro model on the RW0 pins, queue-based reference model, directed tests.
module tb_array_9_port_ctrl;

    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;
    localparam int DATA_W = 1176;
    localparam int MASK_W = 4;
    localparam int LANE_W = DATA_W / MASK_W;
    localparam int RESP_DEPTH = 3;

    logic              clock = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [MASK_W-1:0] req_mask;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              init_done;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_en;
    logic              mem_wmode;
    logic [MASK_W-1:0] mem_wmask;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    array_9_port_ctrl #(
        .ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W), .MASK_W(MASK_W),
        .RESP_DEPTH(RESP_DEPTH), .INIT_ON_RESET(1)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_mask(req_mask), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .init_done(init_done),
        .mem_addr(mem_addr), .mem_en(mem_en), .mem_wmode(mem_wmode),
        .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    // Macro: 1-cycle read latency, lane-masked write; starts with non-zero garbage
    logic [DATA_W-1:0] sram [DEPTH];
    bit primed = 1'b0;
    always @(posedge clock) begin
        if (!primed) begin
            for (int i = 0; i < DEPTH; i++) sram[i] <= {147{8'h5A}};
            primed <= 1'b1;
        end else if (mem_en) begin
            if (mem_wmode) begin
                for (int l = 0; l < MASK_W; l++)
                    if (mem_wmask[l]) sram[mem_addr][l*LANE_W +: LANE_W] <= mem_wdata[l*LANE_W +: LANE_W];
            end else begin
                mem_rdata <= sram[mem_addr];
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chkd(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            for (int l = 0; l < MASK_W; l++) begin
                if (act[l*LANE_W +: LANE_W] !== exp[l*LANE_W +: LANE_W]) begin
                    $display("FAIL %s lane %0d actual=%h required=%h", name, l,
                             act[l*LANE_W +: LANE_W], exp[l*LANE_W +: LANE_W]);
                    break;
                end
            end
        end
    endtask

    function automatic logic [DATA_W-1:0] pat(input logic [7:0] b);
        return {147{b}};
    endfunction

    // Reference model: array contents plus the list of accepted, not yet consumed reads
    typedef struct {
        logic [DATA_W-1:0] d;
        int                t;
    } resp_t;
    resp_t             exp_q [$];
    logic [DATA_W-1:0] shadow [DEPTH];
    int                sweep = DEPTH;
    int                cyc = 0;
    bit                started = 1'b0;

    task automatic model_step();
        bit in_init, rdy, vld, en;
        cyc++;
        if (reset) started = 1'b1;
        if (!started) return;
        if (reset) begin
            chk("rst_req_ready", 64'(req_ready), 64'd0);
            chk("rst_resp_valid", 64'(resp_valid), 64'd0);
            chk("rst_mem_en", 64'(mem_en), 64'd0);
            chk("rst_init_done", 64'(init_done), 64'd0);
            exp_q.delete();
            sweep = 0;
            return;
        end
        in_init = (sweep < DEPTH);
        rdy = !in_init && (exp_q.size() < RESP_DEPTH);
        vld = (exp_q.size() > 0) && (exp_q[0].t + 2 <= cyc);
        en  = in_init || (req_valid && rdy);
        chk("m_req_ready", 64'(req_ready), 64'(rdy));
        chk("m_resp_valid", 64'(resp_valid), 64'(vld));
        chk("m_init_done", 64'(init_done), 64'(!in_init));
        chk("m_mem_en", 64'(mem_en), 64'(en));
        if (in_init) begin
            chk("m_init_wmode", 64'(mem_wmode), 64'd1);
            chk("m_init_addr", 64'(mem_addr), 64'(sweep));
            chk("m_init_wmask", 64'(mem_wmask), 64'hF);
            chkd("m_init_wdata", mem_wdata, '0);
        end else if (en) begin
            chk("m_wmode", 64'(mem_wmode), 64'(req_write));
            chk("m_addr", 64'(mem_addr), 64'(req_addr));
            chk("m_wmask", 64'(mem_wmask), req_write ? 64'(req_mask) : 64'd0);
            if (req_write) chkd("m_wdata", mem_wdata, req_wdata);
        end
        if (vld) chkd("m_rdata", resp_rdata, exp_q[0].d);
        if (in_init) begin
            shadow[sweep] = '0;
            sweep++;
        end else begin
            if (vld && resp_ready) void'(exp_q.pop_front());
            if (req_valid && rdy) begin
                if (req_write) begin
                    for (int l = 0; l < MASK_W; l++)
                        if (req_mask[l]) shadow[req_addr][l*LANE_W +: LANE_W] = req_wdata[l*LANE_W +: LANE_W];
                end else begin
                    exp_q.push_back('{d: shadow[req_addr], t: cyc});
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clock);
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_req(input string name, input logic w, input logic [ADDR_W-1:0] a,
                          input logic [MASK_W-1:0] m, input logic [DATA_W-1:0] d);
        req_valid = 1'b1; req_write = w; req_addr = a; req_mask = m; req_wdata = d;
        #1;
        chk(name, 64'(req_ready), 64'd1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic get_resp(output logic [DATA_W-1:0] d, output bit ok);
        ok = 1'b0;
        d = '0;
        for (int i = 0; i < 10; i++) begin
            if (resp_valid && resp_ready) begin
                d = resp_rdata;
                ok = 1'b1;
                tick();
                return;
            end
            tick();
        end
    endtask

    logic [DATA_W-1:0] got [8];
    logic [DATA_W-1:0] rd;
    logic [LANE_W-1:0] ones;
    bit ok;
    int n, acc, first_c, last_c, vcount;

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_mask = '0; req_wdata = '0; resp_ready = 1'b0;
        ones = '1;
        tick();
        tick();
        reset = 1'b0;
        #1;

        // 1: init sweep then read of addr 5
        for (int i = 0; i < DEPTH; i++) begin
            chk("t1_sweep_en", 64'(mem_en), 64'd1);
            chk("t1_sweep_addr", 64'(mem_addr), 64'(i));
            chk("t1_sweep_ready", 64'(req_ready), 64'd0);
            chk("t1_sweep_done", 64'(init_done), 64'd0);
            tick();
        end
        chk("t1_init_done", 64'(init_done), 64'd1);
        do_req("t1_rd_ready", 1'b0, 3'd5, 4'h0, '0);
        chk("t1_lat1", 64'(resp_valid), 64'd0);
        tick();
        chk("t1_lat2", 64'(resp_valid), 64'd1);
        chkd("t1_rdata", resp_rdata, '0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;

        // 2: masked write then read
        do_req("t2_wr_ready", 1'b1, 3'd3, 4'b0101, '1);
        do_req("t2_rd_ready", 1'b0, 3'd3, 4'h0, '0);
        chk("t2_lat1", 64'(resp_valid), 64'd0);
        tick();
        chk("t2_lat2", 64'(resp_valid), 64'd1);
        chkd("t2_rdata", resp_rdata, {{LANE_W{1'b0}}, ones, {LANE_W{1'b0}}, ones});
        resp_ready = 1'b1;
        tick();

        // 3: fill with distinct patterns, then 8 back-to-back reads
        for (int i = 0; i < DEPTH; i++) do_req("t3_wr_ready", 1'b1, ADDR_W'(i), 4'hF, pat(8'(i)));
        n = 0; acc = 0; first_c = -1; last_c = -1;
        for (int c = 0; c < 12; c++) begin
            req_valid = (c < DEPTH); req_write = 1'b0; req_addr = ADDR_W'(c);
            #1;
            if (req_valid && req_ready) acc++;
            if (resp_valid && n < 8) begin
                got[n] = resp_rdata; n++;
                if (first_c < 0) first_c = c;
                last_c = c;
            end
            tick();
        end
        req_valid = 1'b0;
        chk("t3_accepts", 64'(acc), 64'd8);
        chk("t3_responses", 64'(n), 64'd8);
        chk("t3_no_bubble", 64'(last_c - first_c), 64'd7);
        chkd("t3_first", got[0], pat(8'd0));
        chkd("t3_last", got[7], pat(8'd7));

        // 4: backpressure
        resp_ready = 1'b0; acc = 0;
        for (int c = 0; c < 6; c++) begin
            req_valid = 1'b1; req_write = 1'b0; req_addr = ADDR_W'(1 + c);
            #1;
            if (req_ready) acc++;
            if (resp_valid) chkd("t4_hold", resp_rdata, pat(8'd1));
            tick();
        end
        req_valid = 1'b0;
        chk("t4_accepts", 64'(acc), 64'd3);
        chk("t4_blocked", 64'(req_ready), 64'd0);
        resp_ready = 1'b1; n = 0;
        for (int c = 0; c < 8 && n < 3; c++) begin
            if (resp_valid) begin got[n] = resp_rdata; n++; end
            tick();
        end
        chk("t4_drained", 64'(n), 64'd3);
        chkd("t4_r0", got[0], pat(8'd1));
        chkd("t4_r1", got[1], pat(8'd2));
        chkd("t4_r2", got[2], pat(8'd3));
        chk("t4_ready_back", 64'(req_ready), 64'd1);

        // 5: read/write ordering hazards
        do_req("t5_rd_ready", 1'b0, 3'd2, 4'h0, '0);
        do_req("t5_wr_ready", 1'b1, 3'd2, 4'hF, pat(8'hA5));
        get_resp(rd, ok);
        chk("t5_old_seen", 64'(ok), 64'd1);
        chkd("t5_old", rd, pat(8'd2));
        do_req("t5_wr2_ready", 1'b1, 3'd4, 4'hF, pat(8'h3C));
        do_req("t5_rd2_ready", 1'b0, 3'd4, 4'h0, '0);
        get_resp(rd, ok);
        chk("t5_new_seen", 64'(ok), 64'd1);
        chkd("t5_new", rd, pat(8'h3C));

        // 6: reset with two buffered responses and one read in flight
        resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) do_req("t6_rd_ready", 1'b0, ADDR_W'(i), 4'h0, '0);
        chk("t6_buffered", 64'(resp_valid), 64'd1);
        reset = 1'b1;
        #1;
        chk("t6_rst_valid", 64'(resp_valid), 64'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("t6_after_valid", 64'(resp_valid), 64'd0);
        chk("t6_sweep_en", 64'(mem_en), 64'd1);
        chk("t6_sweep_addr0", 64'(mem_addr), 64'd0);
        resp_ready = 1'b1; vcount = 0;
        for (int c = 0; c < DEPTH + 6; c++) begin
            if (resp_valid) vcount++;
            tick();
        end
        chk("t6_no_stale", 64'(vcount), 64'd0);
        chk("t6_init_done", 64'(init_done), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
